// File: rtl/dram_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single DRAM controller port.
// Port 0 serves the MMU, port 1 the boot loader/DMA path. One access is in
// flight at a time: IDLE selects a requester, ISSUE strobes the controller once,
// WAIT follows busy (with a watchdog), DONE returns a one-cycle ack.
module dram_port_arbiter #(
    parameter int unsigned PRIO    = 0,     // 0: round-robin, 1: port 0 wins ties
    parameter int unsigned TIMEOUT = 4096,  // max WAIT cycles before forced completion
    parameter int unsigned CW      = 13     // watchdog width, 2**CW > TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_ctrl,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_ctrl,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [2:0]  dram_ctrl,
    output logic        dram_we,
    output logic        dram_le,
    input  logic [31:0] dram_odata,
    input  logic        dram_busy,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    // Watchdog value at which a still-busy controller is given up on.
    localparam logic [CW-1:0] WdLast = CW'(TIMEOUT - 1);

    state_t        state;
    logic          owner;    // 0: port 0 owns the access, 1: port 1
    logic          rr_ptr;   // preferred port on a tie under round-robin
    logic [CW-1:0] wdog;

    logic          sel;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_we;
    logic [2:0]    sel_ctrl;

    // Requester selection and operand mux for the IDLE decision.
    always_comb begin
        if (p0_req && p1_req) begin
            sel = (PRIO != 0) ? 1'b0 : rr_ptr;
        end else begin
            sel = !p0_req;
        end
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        sel_we    = sel ? p1_we    : p0_we;
        sel_ctrl  = sel ? p1_ctrl  : p0_ctrl;
    end

    // Sequencer FSM; every output is a register so strobes and acks are glitch-free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= StIdle;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            wdog        <= '0;
            grant       <= 2'b00;
            dram_addr   <= '0;
            dram_wdata  <= '0;
            dram_ctrl   <= '0;
            dram_we     <= 1'b0;
            dram_le     <= 1'b0;
            p0_ack      <= 1'b0;
            p0_rdata    <= '0;
            p0_err      <= 1'b0;
            p1_ack      <= 1'b0;
            p1_rdata    <= '0;
            p1_err      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        owner      <= sel;
                        grant      <= sel ? 2'b10 : 2'b01;
                        dram_addr  <= sel_addr;
                        dram_wdata <= sel_wdata;
                        dram_ctrl  <= sel_ctrl;
                        // Strobe is registered here so it is high exactly during ISSUE.
                        dram_we    <= sel_we;
                        dram_le    <= !sel_we;
                        state      <= StIssue;
                    end
                end

                StIssue: begin
                    dram_we <= 1'b0;
                    dram_le <= 1'b0;
                    wdog    <= '0;
                    state   <= StWait;
                end

                StWait: begin
                    if (!dram_busy) begin
                        if (owner) begin
                            p1_ack   <= 1'b1;
                            p1_rdata <= dram_odata;
                        end else begin
                            p0_ack   <= 1'b1;
                            p0_rdata <= dram_odata;
                        end
                        state <= StDone;
                    end else if (wdog == WdLast) begin
                        // Controller never finished: complete with error, rdata stays 0.
                        timeout_err <= 1'b1;
                        if (owner) begin
                            p1_ack <= 1'b1;
                            p1_err <= 1'b1;
                        end else begin
                            p0_ack <= 1'b1;
                            p0_err <= 1'b1;
                        end
                        state <= StDone;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                StDone: begin
                    p0_ack   <= 1'b0;
                    p0_rdata <= '0;
                    p0_err   <= 1'b0;
                    p1_ack   <= 1'b0;
                    p1_rdata <= '0;
                    p1_err   <= 1'b0;
                    grant    <= 2'b00;
                    // Next tie goes to the port that was just not served.
                    rr_ptr   <= !owner;
                    state    <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: table of single accesses, then
// hand-written sequences for back-to-back, arbitration and mid-access reset.
module tb_dram_port_arbiter;

    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        RST;

    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_we, p1_we;
    logic [2:0]  p0_ctrl, p1_ctrl;
    logic [31:0] dram_odata;
    logic        dram_busy;

    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] dram_addr, dram_wdata;
    logic [2:0]  dram_ctrl;
    logic        dram_we, dram_le;
    logic [1:0]  grant;
    logic        timeout_err;

    logic        f_p0_ack, f_p1_ack, f_p0_err, f_p1_err;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_dram_addr, f_dram_wdata;
    logic [2:0]  f_dram_ctrl;
    logic        f_dram_we, f_dram_le;
    logic [1:0]  f_grant;
    logic        f_timeout_err;

    always #5 CLK = ~CLK;

    dram_port_arbiter #(.PRIO(0), .TIMEOUT(TO), .CW(4)) u_dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_ctrl(p0_ctrl), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_ctrl(p1_ctrl), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ctrl(dram_ctrl),
        .dram_we(dram_we), .dram_le(dram_le), .dram_odata(dram_odata),
        .dram_busy(dram_busy), .grant(grant), .timeout_err(timeout_err)
    );

    // Fixed-priority instance sharing the same stimulus.
    dram_port_arbiter #(.PRIO(1), .TIMEOUT(TO), .CW(4)) u_fix (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_ctrl(p0_ctrl), .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_ctrl(p1_ctrl), .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
        .dram_addr(f_dram_addr), .dram_wdata(f_dram_wdata), .dram_ctrl(f_dram_ctrl),
        .dram_we(f_dram_we), .dram_le(f_dram_le), .dram_odata(dram_odata),
        .dram_busy(dram_busy), .grant(f_grant), .timeout_err(f_timeout_err)
    );

    // Controller model: busy for busy_len cycles starting the cycle after a strobe.
    int unsigned busy_len;
    logic        stuck;
    int unsigned busy_cnt;
    always @(posedge CLK or posedge RST) begin
        if (RST) busy_cnt <= 0;
        else if (dram_le || dram_we) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign dram_busy = stuck || (busy_cnt != 0);

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        int          busy;
        bit          stuck;
        logic [31:0] odata;
        int          lat;
        logic [31:0] rdata;
        bit          err;
        bit          terr;
    } vec_t;
    vec_t vecs[7];

    int   errors = 0;
    int   checks = 0;
    logic [1:0] last_ack;
    int   fix_p0 = 0;
    int   fix_p1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit port, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] ctrl,
                                input int busy, input bit stk, input logic [31:0] odata,
                                input int lat, input logic [31:0] rdata, input bit err,
                                input bit terr);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.ctrl = ctrl;
        v.busy = busy; v.stuck = stk; v.odata = odata; v.lat = lat; v.rdata = rdata;
        v.err = err; v.terr = terr;
        return v;
    endfunction

    function automatic exp_t ex(input bit port, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    // Advance one cycle, sample #1 after the edge and score any ack.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        last_ack = {p1_ack, p0_ack};
        if (f_p0_ack) fix_p0++;
        if (f_p1_ack) fix_p1++;
        if (p0_ack || p1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'b0, p1_ack, p0_ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("ack_port", {30'b0, p1_ack, p0_ack}, e.port ? 32'h2 : 32'h1);
                check("ack_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                check("ack_err", {31'b0, e.port ? p1_err : p0_err}, {31'b0, e.err});
                check("other_rdata", e.port ? p0_rdata : p1_rdata, 32'h0);
                check("other_err", {31'b0, e.port ? p0_err : p1_err}, 32'h0);
            end
        end else begin
            check("noack_rdata", p0_rdata | p1_rdata, 32'h0);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int issue_cyc, ack_cyc, le_n, we_n;
        bit bad_hold, bad_grant;
        issue_cyc = -1; ack_cyc = -1; le_n = 0; we_n = 0;
        bad_hold = 0; bad_grant = 0;
        busy_len = v.busy; stuck = v.stuck; dram_odata = v.odata;
        if (v.port) begin
            p1_addr = v.addr; p1_wdata = v.wdata; p1_we = v.we; p1_ctrl = v.ctrl; p1_req = 1;
        end else begin
            p0_addr = v.addr; p0_wdata = v.wdata; p0_we = v.we; p0_ctrl = v.ctrl; p0_req = 1;
        end
        sb.push_back(ex(v.port, v.rdata, v.err));
        for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
            step();
            if (dram_le) le_n++;
            if (dram_we) we_n++;
            if ((dram_le || dram_we) && issue_cyc < 0) issue_cyc = c;
            if (issue_cyc >= 0) begin
                if (dram_addr !== v.addr || dram_wdata !== v.wdata || dram_ctrl !== v.ctrl)
                    bad_hold = 1;
                if (grant !== (v.port ? 2'b10 : 2'b01)) bad_grant = 1;
            end
            if (last_ack != 2'b00) begin
                ack_cyc = c;
                p0_req = 0;
                p1_req = 0;
            end
        end
        $display("vector %0d: issue at %0d, ack at %0d", idx, issue_cyc, ack_cyc);
        check("issue_cycle", issue_cyc, 1);
        check("ack_latency", ack_cyc - issue_cyc, v.lat);
        check("le_pulses", le_n, v.we ? 0 : 1);
        check("we_pulses", we_n, v.we ? 1 : 0);
        check("dram_hold", {31'b0, bad_hold}, 32'h0);
        check("grant_hold", {31'b0, bad_grant}, 32'h0);
        step();
        check("ack_single", {30'b0, p1_ack, p0_ack}, 32'h0);
        check("grant_idle", {30'b0, grant}, 32'h0);
        check("timeout_err", {31'b0, timeout_err}, {31'b0, v.terr});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int acks[$];
        int n;
        RST = 1'b1;
        p0_req = 0; p1_req = 0; p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        p0_we = 0; p1_we = 0; p0_ctrl = 0; p1_ctrl = 0; dram_odata = 0;
        busy_len = 0; stuck = 0; last_ack = 0;

        vecs[0] = mk(0, 0, 32'h8000_1000, 32'h0,         3'b010, 3, 0, 32'h1234_5678,
                     5, 32'h1234_5678, 0, 0);
        vecs[1] = mk(1, 1, 32'h8000_2000, 32'hCAFE_F00D, 3'b010, 2, 0, 32'h0BAD_BEEF,
                     4, 32'h0BAD_BEEF, 0, 0);
        vecs[2] = mk(0, 0, 32'h0000_0040, 32'h0,         3'b100, 0, 0, 32'hA5A5_5A5A,
                     2, 32'hA5A5_5A5A, 0, 0);
        vecs[3] = mk(1, 0, 32'h1000_0008, 32'h0,         3'b001, 7, 0, 32'h00C0_FFEE,
                     9, 32'h00C0_FFEE, 0, 0);
        vecs[4] = mk(1, 0, 32'h1000_0010, 32'h0,         3'b000, 0, 1, 32'hFFFF_FFFF,
                     9, 32'h0,         1, 1);
        vecs[5] = mk(0, 1, 32'h8000_3000, 32'h1357_9BDF, 3'b011, 1, 0, 32'h0000_0055,
                     3, 32'h0000_0055, 0, 1);
        vecs[6] = mk(0, 0, 32'h8000_4000, 32'h0,         3'b110, 6, 0, 32'h8765_4321,
                     8, 32'h8765_4321, 0, 1);

        // Reset state
        repeat (2) step();
        check("rst_grant", {30'b0, grant}, 32'h0);
        check("rst_strobes", {30'b0, dram_le, dram_we}, 32'h0);
        check("rst_addr", dram_addr, 32'h0);
        check("rst_acks", {28'b0, p0_ack, p1_ack, p0_err, p1_err}, 32'h0);
        RST = 1'b0;
        step();
        check("idle_grant", {30'b0, grant}, 32'h0);
        check("idle_timeout_err", {31'b0, timeout_err}, 32'h0);

        // Single accesses, including timeout and sticky error
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Back-to-back port 0 reads with a zero-busy controller
        busy_len = 0; stuck = 0; dram_odata = 32'h600D_0006;
        p0_addr = 32'h0000_0200; p0_we = 0; p0_ctrl = 3'b010;
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 32'h600D_0006, 0));
        p0_req = 1;
        for (int c = 1; c <= 20 && acks.size() < 3; c++) begin
            step();
            if (last_ack[0]) acks.push_back(c);
            if (acks.size() == 3) p0_req = 0;
        end
        p0_req = 0;
        n = acks.size();
        check("b2b_acks", n, 3);
        if (n == 3) begin
            check("b2b_gap1", acks[1] - acks[0], 4);
            check("b2b_gap2", acks[2] - acks[1], 4);
        end
        step();

        // Both ports held: round-robin alternates, fixed priority starves port 1
        do_reset();
        check("rr_rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        fix_p0 = 0; fix_p1 = 0;
        busy_len = 0; dram_odata = 32'h0000_0077;
        p0_addr = 32'h100; p1_addr = 32'h200; p0_we = 0; p1_we = 0;
        sb.push_back(ex(0, 32'h77, 0));
        sb.push_back(ex(1, 32'h77, 0));
        sb.push_back(ex(0, 32'h77, 0));
        sb.push_back(ex(1, 32'h77, 0));
        p0_req = 1; p1_req = 1;
        repeat (16) step();
        p0_req = 0; p1_req = 0;
        repeat (4) step();
        check("rr_all_acked", sb.size(), 0);
        check("fix_p0_acks", fix_p0, 4);
        check("fix_p1_acks", fix_p1, 0);

        // Reset during WAIT abandons the access; rr_ptr restarts at 0
        sb.delete();
        p0_req = 1;
        sb.push_back(ex(0, 32'h77, 0));
        for (int c = 0; c < 10 && last_ack == 2'b00; c++) step();
        p0_req = 0;
        step();
        busy_len = 5; dram_odata = 32'h5EED_0005;
        p0_req = 1; p1_req = 1;
        step();
        check("pre_rst_grant", {30'b0, grant}, 32'h2);
        step();
        step();
        RST = 1'b1;
        #1;
        check("async_grant", {30'b0, grant}, 32'h0);
        check("async_strobes", {30'b0, dram_le, dram_we}, 32'h0);
        check("async_addr", dram_addr, 32'h0);
        check("async_acks", {30'b0, p0_ack, p1_ack}, 32'h0);
        step();
        RST = 1'b0;
        sb.push_back(ex(0, 32'h5EED_0005, 0));
        step();
        check("post_rst_grant", {30'b0, grant}, 32'h1);
        last_ack = 0;
        for (int c = 0; c < 20 && last_ack == 2'b00; c++) step();
        p0_req = 0; p1_req = 0;
        repeat (3) step();
        check("post_rst_acked", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
